// File: rtl/cp0_if.sv
// rtl/cp0_if.sv - CP0 register/interrupt bus between datapath and coprocessor 0
interface cp0_if;
    logic [31:0] wr_data;
    logic [4:0]  regnum;
    logic        MTC0;
    logic        ERET;
    logic [29:0] next_pc;
    logic        TimerInterrupt;
    logic [4:0]  ext_irq;
    logic [31:0] rd_data;
    logic [29:0] EPC;
    logic        TakenInterrupt;

    // Datapath side: drives strobes and interrupt lines, reads CP0 results
    modport master (
        output wr_data, regnum, MTC0, ERET, next_pc, TimerInterrupt, ext_irq,
        input  rd_data, EPC, TakenInterrupt
    );

    // Coprocessor side
    modport slave (
        input  wr_data, regnum, MTC0, ERET, next_pc, TimerInterrupt, ext_irq,
        output rd_data, EPC, TakenInterrupt
    );
endinterface

// File: rtl/cp0.sv
// rtl/cp0.sv - Coprocessor-0 interrupt controller (Status/Cause/EPC, mtc0/mfc0/eret)
module cp0 #(
    parameter logic [29:0] EPC_RESET = 30'h0
) (
    input  logic clock,
    input  logic reset,
    cp0_if.slave bus
);
    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;

    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic [1:0]  r_sw;
    logic [29:0] r_epc;

    logic [7:0]  w_ip;
    logic        w_taken;
    logic [31:0] w_status;
    logic [31:0] w_cause;

    // Pending vector and live composite register images
    assign w_ip     = {bus.TimerInterrupt, bus.ext_irq, r_sw};
    assign w_taken  = (|(w_ip & r_im)) & r_ie & ~r_exl;
    assign w_status = {16'h0, r_im, 6'h0, r_exl, r_ie};
    assign w_cause  = {16'h0, bus.TimerInterrupt, bus.ext_irq, r_sw, 8'h0};

    assign bus.TakenInterrupt = w_taken;
    assign bus.EPC            = r_epc;

    // mfc0 read mux: purely from current state and live Cause lines
    always_comb begin
        bus.rd_data = 32'h0;
        case (bus.regnum)
            REG_STATUS: bus.rd_data = w_status;
            REG_CAUSE:  bus.rd_data = w_cause;
            REG_EPC:    bus.rd_data = {r_epc, 2'b00};
            default:    bus.rd_data = 32'h0;
        endcase
    end

    // State update: interrupt entry beats eret, eret's EXL clear beats an mtc0 to Status
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_im  <= 8'h0;
            r_exl <= 1'b0;
            r_ie  <= 1'b0;
            r_sw  <= 2'b0;
            r_epc <= EPC_RESET;
        end else if (w_taken) begin
            // The mtc0/eret instruction in flight is flushed, so both are dropped
            r_exl <= 1'b1;
            r_epc <= bus.next_pc;
        end else begin
            if (bus.MTC0) begin
                case (bus.regnum)
                    REG_STATUS: begin
                        r_im  <= bus.wr_data[15:8];
                        r_exl <= bus.wr_data[1];
                        r_ie  <= bus.wr_data[0];
                    end
                    REG_CAUSE: r_sw  <= bus.wr_data[9:8];
                    REG_EPC:   r_epc <= bus.wr_data[31:2];
                    default: ;
                endcase
            end
            if (bus.ERET) begin
                r_exl <= 1'b0;
            end
        end
    end
endmodule

// File: doc/cp0.md
# cp0

Coprocessor-0 interrupt controller for the single-cycle MIPS datapath. It consumes the timer's `TimerInterrupt` line and up to five external interrupt lines, and masks them against the Status register. It decides when the processor takes an interrupt, records the return PC in EPC, and services `mtc0`/`mfc0`/`eret`. It sits between the memory-mapped timer and the PC-select / fetch logic.

## Interface
Parameters:
- `EPC_RESET`, 30'h0: reset value of EPC (word address).

Ports:
- `clock`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low (asserted at 0); clears all state immediately.
- `wr_data`  in  32  `mtc0` source data (rt value).
- `regnum`  in  5  CP0 register number (rd field) for `mtc0`/`mfc0`.
- `MTC0`  in  1  write strobe for `wr_data` into register `regnum`.
- `ERET`  in  1  return-from-exception strobe.
- `next_pc`  in  30  word address of the instruction that would execute next; saved on interrupt.
- `TimerInterrupt`  in  1  level from the timer block.
- `ext_irq`  in  5  external interrupt levels.
- `rd_data`  out  32  `mfc0` read value for `regnum`.
- `EPC`  out  30  saved return word address; PC logic uses `{EPC,2'b00}` on `ERET`.
- `TakenInterrupt`  out  1  PC must redirect to the handler this cycle.

## Operation
- Status (reg 12): bits [15:8] IM (writable), bit 1 EXL (writable), bit 0 IE (writable); all other bits read 0.
- Cause (reg 13):
  - bit 15 = `TimerInterrupt` (live, read-only).
  - bits [14:10] = `ext_irq[4:0]` (live, read-only).
  - bits [9:8] = software interrupt bits SW[1:0] (writable); all other bits read 0.
- EPC (reg 14): reads `{EPC,2'b00}`. An `mtc0` write stores `wr_data[31:2]`.
- Any other `regnum` reads 32'h0; writes to it are ignored.
- `rd_data` is combinational from current register state and live Cause inputs, independent of `MTC0`.
- Pending vector: `IP[7:0] = {TimerInterrupt, ext_irq, SW}`.
- `TakenInterrupt = |(IP & IM) & IE & ~EXL` (combinational).
- Priority at each edge:
  - If `TakenInterrupt`: EXL←1, EPC←`next_pc`. Any simultaneous `MTC0` is squashed because its instruction is flushed. A simultaneous `ERET` is ignored.
  - Otherwise, if `ERET`: EXL←0. A simultaneous `MTC0` is also applied; if that write targets Status, `ERET`'s EXL clear wins for bit 1, and the written value applies to all other bits.
  - Otherwise, if `MTC0`: write the register selected by `regnum`.
- Interrupt lines are levels. The handler must acknowledge the source (e.g. timer ack write) or mask it before `eret`, otherwise the interrupt is re-taken on the next cycle.

## Timing
- Reset (`reset`=0): Status=0, SW=0, EPC=`EPC_RESET`, regardless of clock. Outputs during reset:
  - `TakenInterrupt`=0.
  - `rd_data` = 0 for Status/EPC; Cause shows the live lines.
  - `EPC`=`EPC_RESET`.
- Reset release: state updates on the first rising edge after `reset` returns to 1.
- Register writes have 1-cycle latency: an `mtc0` on edge N is visible on `rd_data` and in `TakenInterrupt` after edge N.
- `TakenInterrupt` has 0-cycle latency from `TimerInterrupt`/`ext_irq` and from the current IE/IM/EXL.
- After a taken interrupt, `TakenInterrupt` drops to 0 immediately following the edge, because EXL=1.
- Once the handler clears EXL via `eret`, `TakenInterrupt` may re-assert on the next cycle.
- A mid-handler `reset` clears EXL and EPC; no interrupt is taken until software sets IE again.

## Test plan
- **Reset:** `reset`=0 with `TimerInterrupt`=1 → `TakenInterrupt`=0; `rd_data`(reg 12)=0; `rd_data`(reg 13)=32'h8000; `EPC`=0.
- **Enable and take:** `mtc0` Status=32'h8001, then raise `TimerInterrupt` with `next_pc`=30'h100 → `TakenInterrupt`=1 in that cycle. After the edge: `EPC`=30'h100, `rd_data`(reg 14)=32'h400, Status reads 32'h8003, `TakenInterrupt`=0.
- **Masking:** Status=32'h0401 (IM bit 10 only), `TimerInterrupt`=1 → no interrupt. Then `ext_irq`=5'b00001 → `TakenInterrupt`=1.
- **ERET:** from EXL=1 with the timer acknowledged, `ERET` → EXL=0, Status=32'h8001, `TakenInterrupt` stays 0. Repeat without the ack → `TakenInterrupt`=1 the cycle after `ERET`.
- **Collision:** `TakenInterrupt`=1 together with `MTC0` to Status of 32'h0 → after the edge Status=32'h8003 (write squashed).
- **Software interrupt and async reset:** `mtc0` Cause=32'h100 with Status=32'h0101 → take; then pull `reset` low mid-cycle → Status/EPC read 0 before the next edge.
